// File: rtl/triangle_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : triangle_mem_arbiter
//  Purpose  : Shares the single-port triangle BRAM between the execute stage
//             (EXEC, port 0, loads and stores) and the rasterization
//             controller (RAST, port 1, loads only). Grants are issued
//             combinationally in the request cycle. Each read is tracked
//             through a READ_LATENCY-deep {valid, tag} pipeline so that the
//             returning data is steered only to the requester that issued it.
//
//  Ports    : clk, rst                     - clock, synchronous active-high reset
//             exec_req/we/addr/wdata       - EXEC request side
//             exec_gnt/rvalid/rdata        - EXEC grant and load return
//             rast_req/addr                - RAST read request side
//             rast_gnt/rvalid/rdata        - RAST grant and read return
//             mem_en/we/addr/wdata/rdata   - BRAM port
//             busy                         - at least one read in flight
//             exec_stall_rast              - (optional) RAST held off by EXEC
//
//  Options  : TRI_MEM_ARB_EXEC_PRIO_EN - when defined, EXEC has fixed
//             priority over RAST and the exec_stall_rast output is added.
//             When undefined, arbitration is round-robin.
//
//  Revision : 1.0 - initial release
// ============================================================================
module triangle_mem_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 288,
    parameter int READ_LATENCY = 2     // legal range 1..4
) (
    input  logic              clk,
    input  logic              rst,

    // EXEC port
    input  logic              exec_req,
    input  logic              exec_we,
    input  logic [ADDR_W-1:0] exec_addr,
    input  logic [DATA_W-1:0] exec_wdata,
    output logic              exec_gnt,
    output logic              exec_rvalid,
    output logic [DATA_W-1:0] exec_rdata,

    // RAST port
    input  logic              rast_req,
    input  logic [ADDR_W-1:0] rast_addr,
    output logic              rast_gnt,
    output logic              rast_rvalid,
    output logic [DATA_W-1:0] rast_rdata,

    // BRAM port
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

`ifdef TRI_MEM_ARB_EXEC_PRIO_EN
    output logic              exec_stall_rast,
`endif
    output logic              busy
);

    // Index of the pipeline stage whose data coincides with mem_rdata.
    localparam int c_LAST = READ_LATENCY - 1;

    // Requester identity; also used as the tag stored with each read.
    typedef enum logic {
        PORT_EXEC = 1'b0,
        PORT_RAST = 1'b1
    } port_e;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    port_e                   last_gnt_q;
    port_e                   last_gnt_d;
    logic [READ_LATENCY-1:0] pipe_vld_q;   // bit i: read issued i+1 cycles ago
    logic [READ_LATENCY-1:0] pipe_tag_q;   // matching requester (1 = RAST)
    logic [DATA_W-1:0]       exec_hold_q;  // last data returned to EXEC
    logic [DATA_W-1:0]       rast_hold_q;  // last data returned to RAST

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic w_exec_win;
    logic w_rast_win;
    logic w_rd_gnt;
    logic w_ret_vld;
    logic w_ret_rast;

    // ------------------------------------------------------------------------
    // Arbitration. Grants are suppressed while in reset so that every output
    // is quiet during reset regardless of what the requesters drive.
    // ------------------------------------------------------------------------
    always_comb begin
        w_exec_win = 1'b0;
        w_rast_win = 1'b0;
        if (!rst) begin
`ifdef TRI_MEM_ARB_EXEC_PRIO_EN
            // Fixed priority: RAST only gets the memory when EXEC is idle.
            w_exec_win = exec_req;
            w_rast_win = rast_req & ~exec_req;
`else
            if (exec_req && rast_req) begin
                // Tie: the requester that did not win last time goes first.
                w_exec_win = (last_gnt_q == PORT_RAST);
                w_rast_win = (last_gnt_q == PORT_EXEC);
            end else begin
                w_exec_win = exec_req;
                w_rast_win = rast_req;
            end
`endif
        end
    end

    assign exec_gnt = w_exec_win;
    assign rast_gnt = w_rast_win;

`ifdef TRI_MEM_ARB_EXEC_PRIO_EN
    // exec_gnt is already forced low in reset, so this is 0 in reset too.
    assign exec_stall_rast = rast_req & w_exec_win;
`endif

    // Remember who was served last; only changes on a grant.
    always_comb begin
        last_gnt_d = last_gnt_q;
        if (w_exec_win) begin
            last_gnt_d = PORT_EXEC;
        end else if (w_rast_win) begin
            last_gnt_d = PORT_RAST;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_q <= PORT_RAST;   // EXEC wins the first tie after reset
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Memory drive. RAST never writes, so the write strobe and write data
    // come only from an EXEC store; write data is zeroed otherwise.
    // ------------------------------------------------------------------------
    assign mem_en    = w_exec_win | w_rast_win;
    assign mem_we    = w_exec_win & exec_we;
    assign mem_wdata = mem_we ? exec_wdata : '0;

    always_comb begin
        mem_addr = '0;
        if (w_exec_win) begin
            mem_addr = exec_addr;
        end else if (w_rast_win) begin
            mem_addr = rast_addr;
        end
    end

    // A read is any RAST grant or an EXEC grant that is not a store.
    assign w_rd_gnt = w_rast_win | (w_exec_win & ~exec_we);

    // ------------------------------------------------------------------------
    // Read tracking pipeline: one shift per cycle, entry 0 takes the new read.
    // ------------------------------------------------------------------------
    generate
        if (READ_LATENCY == 1) begin : g_pipe_single
            always_ff @(posedge clk) begin
                if (rst) begin
                    pipe_vld_q <= '0;
                    pipe_tag_q <= '0;
                end else begin
                    pipe_vld_q <= w_rd_gnt;
                    pipe_tag_q <= w_rast_win;
                end
            end
        end else begin : g_pipe_multi
            always_ff @(posedge clk) begin
                if (rst) begin
                    pipe_vld_q <= '0;
                    pipe_tag_q <= '0;
                end else begin
                    pipe_vld_q <= {pipe_vld_q[READ_LATENCY-2:0], w_rd_gnt};
                    pipe_tag_q <= {pipe_tag_q[READ_LATENCY-2:0], w_rast_win};
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Read return. The oldest pipeline entry lines up with mem_rdata; its tag
    // picks the destination. Data is passed straight through in the return
    // cycle and held in a per-port register afterwards so that the port not
    // being served keeps showing its previous data.
    // ------------------------------------------------------------------------
    assign w_ret_vld  = pipe_vld_q[c_LAST] & ~rst;
    assign w_ret_rast = pipe_tag_q[c_LAST];

    assign exec_rvalid = w_ret_vld & ~w_ret_rast;
    assign rast_rvalid = w_ret_vld &  w_ret_rast;

    always_ff @(posedge clk) begin
        if (rst) begin
            exec_hold_q <= '0;
            rast_hold_q <= '0;
        end else begin
            if (exec_rvalid) begin
                exec_hold_q <= mem_rdata;
            end
            if (rast_rvalid) begin
                rast_hold_q <= mem_rdata;
            end
        end
    end

    always_comb begin
        exec_rdata = exec_hold_q;
        rast_rdata = rast_hold_q;
        if (rst) begin
            exec_rdata = '0;
            rast_rdata = '0;
        end else begin
            if (exec_rvalid) begin
                exec_rdata = mem_rdata;
            end
            if (rast_rvalid) begin
                rast_rdata = mem_rdata;
            end
        end
    end

    // Any read still travelling through the pipeline.
    assign busy = (|pipe_vld_q) & ~rst;

endmodule
`default_nettype wire

// File: doc/triangle_mem_arbiter.md
Name: triangle_mem_arbiter

Overview:
- Arbitrates the single-port triangle memory between two requesters:
  - Port 0 (EXEC): the execute stage, loading and storing triangles.
  - Port 1 (RAST): the rasterization controller, fetching the next triangle.
- Round-robin grant; tracks in-flight reads through a READ_LATENCY-deep tag pipeline; returns read data to the issuing requester only.
- Sits between the execute stage / rasterization controller and the triangle BRAM.

Parameters:
- ADDR_W, 10, triangle address width (TriangleAddr).
- DATA_W, 288, packed Triangle width.
- READ_LATENCY, 2, BRAM read latency in cycles (legal 1..4).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- exec_req  in  1  EXEC request; held until exec_gnt
- exec_we  in  1  1=store, 0=load
- exec_addr  in  ADDR_W  EXEC triangle address
- exec_wdata  in  DATA_W  EXEC store data
- exec_gnt  out  1  EXEC request accepted this cycle
- exec_rvalid  out  1  EXEC load data valid
- exec_rdata  out  DATA_W  EXEC load data
- rast_req  in  1  RAST read request; held until rast_gnt
- rast_addr  in  ADDR_W  RAST triangle address
- rast_gnt  out  1  RAST request accepted this cycle
- rast_rvalid  out  1  RAST read data valid
- rast_rdata  out  DATA_W  RAST read data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid READ_LATENCY cycles after mem_en with mem_we=0
- busy  out  1  at least one read in flight

Behaviour:
- Reset:
  - All outputs 0.
  - Round-robin pointer last_gnt=RAST, so EXEC wins the first tie.
  - Tag pipeline cleared.
- Grant is combinational in the request cycle:
  - At most one of exec_gnt/rast_gnt per cycle.
  - A grant is issued whenever any request is high; no bubbles.
- Arbitration:
  - One requester high: it is granted.
  - Both high: the requester not equal to last_gnt is granted.
  - last_gnt updates on the clock edge of every grant.
- Memory drive:
  - mem_en = exec_gnt | rast_gnt.
  - mem_addr/mem_wdata/mem_we are muxed from the granted port.
  - mem_we is 0 whenever RAST is granted.
  - mem_wdata = 0 when not writing.
- Read tracking:
  - Shift register of READ_LATENCY entries {valid, tag}, one shift per cycle.
  - Entry 0 is loaded on a read grant with valid=1 and tag=granted port; otherwise valid=0.
  - When the last entry is valid: its tag's rvalid=1 for exactly one cycle; rdata = mem_rdata, passed through combinationally.
  - Non-selected port's rdata holds its previous value; rvalid=0.
- Writes:
  - Single-cycle, no response beyond exec_gnt.
  - A read to the same address granted in a later cycle returns the new data (BRAM write-first assumption lives in the memory).
- Throughput: back-to-back grants every cycle; up to READ_LATENCY reads in flight; no backpressure on rvalid, so requesters must accept return data.
- busy = OR of the pipeline valid bits.
- Request withdrawn before grant: legal; no memory access occurs.
- Reset mid-operation: pipeline cleared; in-flight reads never produce rvalid.

Optional Feature:
- Macro: TRI_MEM_ARB_EXEC_PRIO_EN.
- Defined:
  - Fixed priority; EXEC always wins a tie.
  - RAST is granted only when exec_req=0.
  - last_gnt is still maintained but unused.
  - Adds output exec_stall_rast (1 bit): high in any cycle rast_req=1 and exec_gnt=1. Reset value 0.
- Undefined: round-robin as above; exec_stall_rast is absent.

Test Plan:
- Reset, then exec_req read addr 5 alone (mem holds T5):
  - exec_gnt same cycle, mem_addr=5.
  - exec_rvalid=1 with rdata=T5 exactly 2 cycles later.
  - rast_rvalid stays 0.
- exec_req and rast_req both held high for 4 cycles, reads at addr 1/2:
  - Grants alternate EXEC, RAST, EXEC, RAST.
  - Each rvalid arrives on the matching port 2 cycles after its grant.
- EXEC store addr 7 = 0xABC, next cycle RAST read addr 7:
  - mem_we=1 on the first cycle, 0 on the second.
  - rast_rdata=0xABC after 2 cycles.
- RAST reads addr 0..3 back-to-back:
  - Four consecutive grants; rast_rvalid high for 4 consecutive cycles starting cycle 2 with data T0..T3.
  - busy high throughout.
- Read granted, rst asserted the next cycle:
  - No rvalid on either port.
  - busy=0 after reset.
  - Next tie after reset grants EXEC.
- With TRI_MEM_ARB_EXEC_PRIO_EN, both requesting for 3 cycles:
  - EXEC granted all 3 cycles; exec_stall_rast=1 all 3 cycles.
  - RAST granted in the cycle after exec_req drops.
